// File: rtl/inv_pi_pkg.sv
// Shared constants, FSM encoding and mod-5 lookup for the inverse pi-lane permutation unit.
package inv_pi_pkg;

    localparam int SIZE    = 5;
    localparam int MEMSIZE = SIZE * SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Entry n (bits [3n+:3]) holds n mod 5 for n = 0..20, the full range of 2i+3j.
    localparam logic [62:0] MOD5_TABLE = {
        3'd0,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0
    };

    function automatic logic [2:0] mod5_lookup(input logic [4:0] value);
        logic [62:0] table_bits;
        table_bits = MOD5_TABLE;
        return table_bits[3*value +: 3];
    endfunction

endpackage

// File: rtl/inv_pi_unit_mod5_reduce.sv
// Combinational mod-5 reduction of a 5-bit value in 0..20 by repeated conditional subtraction.
module mod5_reduce (
    input  logic [4:0] value_in,
    output logic [2:0] value_out
);

    logic [4:0] partial;

    // Three subtraction stages bring 20 down to 5; the last stage folds into the output.
    always_comb begin
        partial = value_in;
        for (int k = 0; k < 3; k++) begin
            if (partial >= 5'd5) begin
                partial = partial - 5'd5;
            end
        end
        value_out = (partial >= 5'd5) ? 3'(partial - 5'd5) : partial[2:0];
    end

endmodule

// File: rtl/inv_pi_unit.sv
// Inverse pi-lane permutation of a 5x5 slice, one cell per cycle.
// Optional parity cross-check enabled by defining INV_PI_PARITY_EN.
module inv_pi_unit
    import inv_pi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MEMSIZE-1:0] line,
    output logic               busy,
    output logic               done,
    output logic [MEMSIZE-1:0] out_line
`ifdef INV_PI_PARITY_EN
    ,
    output logic               parity_ok
`endif
);

    state_e             state_q, state_d;
    logic [2:0]         i_q, i_d;
    logic [2:0]         j_q, j_d;
    logic [MEMSIZE-1:0] in_q, in_d;
    logic [MEMSIZE-1:0] out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [4:0] diag_sum;
    logic [2:0] diag_mod;
    logic [4:0] src_idx;
    logic [4:0] dst_idx;
    logic       src_bit;

    assign diag_sum = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0} + {2'b00, j_q};

    mod5_reduce u_mod5 (
        .value_in  (diag_sum),
        .value_out (diag_mod)
    );

    assign src_idx = {j_q, 2'b00} + {2'b00, j_q} + {2'b00, diag_mod};
    assign dst_idx = {i_q, 2'b00} + {2'b00, i_q} + {2'b00, j_q};
    assign src_bit = in_q[src_idx];

`ifdef INV_PI_PARITY_EN
    logic xor_out_q, xor_out_d;
    logic parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        in_d    = in_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef INV_PI_PARITY_EN
        xor_out_d = xor_out_q;
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    in_d    = line;
                    out_d   = '0;
                    i_d     = 3'd0;
                    j_d     = 3'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef INV_PI_PARITY_EN
                    xor_out_d = 1'b0;
                    parity_d  = 1'b1;
`endif
                end
            end
            RUN: begin
                out_d[dst_idx] = src_bit;
`ifdef INV_PI_PARITY_EN
                xor_out_d = xor_out_q ^ src_bit;
`endif
                if (j_q == 3'd4) begin
                    j_d = 3'd0;
                    if (i_q == 3'd4) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef INV_PI_PARITY_EN
                parity_d = ((^in_q) == xor_out_q);
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            in_q    <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef INV_PI_PARITY_EN
            xor_out_q <= 1'b0;
            parity_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            in_q    <= in_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef INV_PI_PARITY_EN
            xor_out_q <= xor_out_d;
            parity_q  <= parity_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out_line = out_q;
`ifdef INV_PI_PARITY_EN
    assign parity_ok = parity_q;
`endif

endmodule

// File: tb/tb_inv_pi_unit.sv
// Directed and round-trip bench for inv_pi_unit; parity checks follow INV_PI_PARITY_EN.
module tb_inv_pi_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [24:0] line_in;
    logic        busy;
    logic        done;
    logic [24:0] out_line;
`ifdef INV_PI_PARITY_EN
    logic        parity_ok;
`endif

    int vectors;
    int miscompares;

    logic [24:0] pass_result;
    int          pass_latency;

    inv_pi_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .line     (line_in),
        .busy     (busy),
        .done     (done),
        .out_line (out_line)
`ifdef INV_PI_PARITY_EN
        ,
        .parity_ok(parity_ok)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Forward pi move: cell (i,j) lands at (j, (2i+3j) mod 5).
    function automatic logic [24:0] fwd_model(input logic [24:0] x);
        logic [24:0] y;
        y = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                y[5*j + ((2*i + 3*j) % 5)] = x[5*i + j];
            end
        end
        return y;
    endfunction

    // Accept counts as edge 1, so done should appear on edge 26; glitch_at>0 pulses start mid-RUN.
    task automatic applyStimulus(input logic [24:0] value, input int glitch_at);
        int edges;
        @(negedge clk);
        line_in = value;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        line_in = ~value;
        edges   = 1;
        while (!done && edges < 40) begin
            if (glitch_at > 0 && edges == glitch_at) begin
                start   = 1'b1;
                line_in = 25'h0A5A5A5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
        if (!done) begin
            checkOutput("done_timeout", 32'(edges), 32'd26);
        end
        pass_latency = edges;
        pass_result  = out_line;
        @(posedge clk);
        #1;
`ifdef INV_PI_PARITY_EN
        checkOutput("parity_ok", 32'(parity_ok), 32'd1);
`endif
    endtask

    initial begin
        logic [24:0] x;
        bit          saw_done;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b1;
        line_in     = 25'h1FFFFFF;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_out", 32'(out_line), 32'd0);
`ifdef INV_PI_PARITY_EN
        checkOutput("reset_parity", 32'(parity_ok), 32'd1);
`endif
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(25'h0000001, 0);
        checkOutput("fixed_point", 32'(pass_result), 32'h0000001);
        checkOutput("latency", 32'(pass_latency), 32'd26);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        applyStimulus(25'h0000100, 0);
        checkOutput("cell_1_3", 32'(pass_result), 32'h0000002);

        applyStimulus(25'h1000000, 0);
        checkOutput("cell_4_4", 32'(pass_result), 32'h0000200);

        applyStimulus(25'h1FFFFFF, 0);
        checkOutput("all_ones", 32'(pass_result), 32'h1FFFFFF);

        applyStimulus(25'h0000000, 0);
        checkOutput("all_zero", 32'(pass_result), 32'h0000000);
        line_in = 25'h1234567;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("hold_zero", 32'(out_line), 32'h0000000);

        for (int n = 0; n < 100; n++) begin
            x = 25'($urandom);
            applyStimulus(fwd_model(x), (n % 10 == 3) ? 10 : 0);
            checkOutput("round_trip", 32'(pass_result), 32'(x));
            if (n % 10 == 3) begin
                checkOutput("glitch_latency", 32'(pass_latency), 32'd26);
            end
        end

        // Abort a pass partway through and make sure no done pulse escapes.
        @(negedge clk);
        line_in = 25'h1FFFFFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_out", 32'(out_line), 32'h0000000);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst      = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", 32'(saw_done), 32'd0);

        x = 25'h0ABCDEF;
        applyStimulus(fwd_model(x), 0);
        checkOutput("post_abort", 32'(pass_result), 32'(x));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
